odd_cnt_sched: RTL and testbench
================================

# odd_cnt_sched

Command-driven controller that sequences the odd counter datapath. Accepts a burst command (odd start value, count length) over a valid/ready handshake. Steps an internal odd counter core one value per cycle, with a pause input. Reports completion with a single-cycle done pulse. Sits between a host/sequencer and any consumer of the odd-number stream.

## Interface
Parameters:
- CNT_W, 8, width of count value and burst length.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  controller can accept a command.
- cmd_start_i  in  CNT_W  first value; LSB forced to 1 on capture.
- cmd_len_i  in  CNT_W  number of values to emit (0 allowed).
- hold_i  in  1  pause stepping while high.
- cnt_o  out  CNT_W  current odd value.
- cnt_valid_o  out  1  cnt_o carries a new value this cycle.
- done_o  out  1  one-cycle pulse at burst end.
- ovf_o  out  1  one-cycle pulse: burst truncated at max value (only without wrap).
- busy_o  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - cmd_ready_o=1.
  - Handshake completes on a rising edge with cmd_valid_i & cmd_ready_o.
  - Captures start = cmd_start_i | 1 and rem = cmd_len_i.
  - len≠0 goes to LOAD; len=0 goes straight to DONE.
- LOAD:
  - One cycle; loads the core with start.
  - cmd_ready_o=0, cnt_valid_o=0.
- RUN, each edge with hold_i=0:
  - Registers cnt_o = core value and cnt_valid_o=1.
  - Advances the core by 2 and decrements rem.
  - After emitting the value with rem=1, goes to DONE.
- RUN with hold_i=1 at an edge:
  - Next cycle cnt_valid_o=0; cnt_o, core value and rem unchanged.
- DONE:
  - done_o=1 for exactly one cycle, then IDLE.
  - cmd_valid_i is ignored in DONE.
- Arithmetic:
  - Core increments modulo 2^CNT_W; only odd values ever appear on cnt_o.
  - The value after 2^CNT_W−1 is 1 (wrap handling depends on configuration).
- Reset:
  - All outputs 0 (cnt_o=0, cnt_valid_o=0, done_o=0, ovf_o=0, busy_o=0, cmd_ready_o=0) in the reset cycle.
  - State IDLE afterwards, so cmd_ready_o=1 in the first cycle after reset deasserts.
- Reset mid-burst:
  - Aborts immediately.
  - No done_o or ovf_o is produced; the pending command is discarded.

## Timing
- Command accepted at edge k:
  - LOAD in cycle k+1.
  - First cnt_valid_o in cycle k+2, with cnt_o=start.
- Without hold: N values in N consecutive cycles.
  - done_o is asserted the cycle after the last value; cmd_ready_o returns one cycle after done_o.
- Each sampled hold_i=1 in RUN adds exactly one cycle of latency.
- len=0: done_o in cycle k+1; no cnt_valid_o.
- Outputs are registered; no combinational input-to-output paths.
  - Exception: cmd_ready_o is a decode of the state register.

## Configuration
- Macro ODD_CNT_SCHED_WRAP_EN.
- Defined: a burst crossing 2^CNT_W−1 continues at 1, 3, … until rem is exhausted; ovf_o is tied 0.
- Undefined:
  - Once 2^CNT_W−1 is emitted with rem>1, the burst ends.
  - The next cycle asserts done_o and ovf_o together; the remaining count is dropped.

## Structure
- Shared package odd_cnt_pkg holds:
  - state enum (IDLE, LOAD, RUN, DONE);
  - default CNT_W;
  - constant ODD_STEP=2;
  - function force_odd().
- Sub-module odd_cnt_core holds the odd counter datapath:
  - inputs clk, reset, load, load_val, step;
  - output value.
  - odd_cnt_sched instantiates it and owns the FSM, rem counter and handshake.

## Test plan
- start=3, len=4, hold_i=0 → cnt_o 3,5,7,9 on four consecutive valid cycles beginning 2 cycles after acceptance; done_o the next cycle; ready the cycle after.
- start=4, len=2 → 5,7 (LSB forced); done_o after 7.
- len=0 → no cnt_valid_o; done_o in cycle after acceptance.
- start=1, len=3, hold_i high for 2 cycles after the first value → 1, two invalid cycles with cnt_o=1, then 3,5; done_o after 5.
- start=253, len=4:
  - with WRAP_EN → 253,255,1,3 then done_o, ovf_o=0;
  - without → 253,255 then done_o=ovf_o=1 in the same cycle.
- reset asserted during RUN after value 7 → outputs 0 next cycle, no done_o; new command start=1, len=1 afterwards → 1 then done_o.

Source files
------------

// File: rtl/odd_cnt_pkg.sv
// -----------------------------------------------------------------------------
// odd_cnt_pkg
// Shared definitions for the odd counter scheduler and its datapath core:
//   state_e    - controller states (IDLE, LOAD, RUN, DONE)
//   CNT_W_DEF  - default width of count values and burst lengths
//   ODD_STEP   - distance between consecutive odd values
//   force_odd  - sets the LSB so any captured start value is odd
// -----------------------------------------------------------------------------
package odd_cnt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int CNT_W_DEF = 8;
    localparam int ODD_STEP  = 2;

    // Wide on purpose so callers of any CNT_W up to 64 can size-cast the result.
    function automatic logic [63:0] force_odd(input logic [63:0] v);
        return v | 64'd1;
    endfunction

endpackage

// File: rtl/odd_cnt_sched_if.sv
// -----------------------------------------------------------------------------
// odd_cnt_sched_if
// Burst command channel between a host/sequencer and odd_cnt_sched.
//   cmd_valid_i  host offers a command
//   cmd_ready_o  controller can accept a command
//   cmd_start_i  first value of the burst (LSB forced to 1 on capture)
//   cmd_len_i    number of values to emit (0 allowed)
// Modports: master (host side), slave (controller side).
// -----------------------------------------------------------------------------
interface odd_cnt_sched_if
    import odd_cnt_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic [CNT_W-1:0] cmd_start_i;
    logic [CNT_W-1:0] cmd_len_i;

    modport master (
        output cmd_valid_i,
        output cmd_start_i,
        output cmd_len_i,
        input  cmd_ready_o
    );

    modport slave (
        input  cmd_valid_i,
        input  cmd_start_i,
        input  cmd_len_i,
        output cmd_ready_o
    );
endinterface

// File: rtl/odd_cnt_core.sv
// -----------------------------------------------------------------------------
// odd_cnt_core
// Odd counter datapath register. Load has priority over step; stepping adds
// ODD_STEP modulo 2^CNT_W, so the value after 2^CNT_W-1 is 1.
// Ports:
//   clk, reset  clock / synchronous active-high reset (value -> 0)
//   load        load value with load_val
//   load_val    odd value to load
//   step        advance value by ODD_STEP
//   value       current counter value
// -----------------------------------------------------------------------------
module odd_cnt_core
    import odd_cnt_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             step,
    output logic [CNT_W-1:0] value
);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (step) begin
            value <= value + CNT_W'(ODD_STEP);
        end
    end

endmodule

// File: rtl/odd_cnt_sched.sv
// -----------------------------------------------------------------------------
// odd_cnt_sched
// Command-driven controller sequencing the odd counter core. A burst command
// (odd start, length) is accepted over a valid/ready handshake; the core then
// emits one odd value per cycle on cnt_o, pausing while hold_i is sampled high,
// and done_o pulses for one cycle after the last value.
//
// Ports:
//   clk, reset    clock / synchronous active-high reset
//   cmd           odd_cnt_sched_if.slave command channel
//   hold_i        pause stepping while high (RUN only)
//   cnt_o         current odd value (the core register itself)
//   cnt_valid_o   cnt_o carries a new value this cycle
//   done_o        one-cycle pulse at burst end
//   ovf_o         one-cycle pulse with done_o when a burst is truncated at the
//                 maximum value (never set when wrapping is enabled)
//   busy_o        high whenever the controller is not IDLE
//
// Configuration macro: ODD_CNT_SCHED_WRAP_EN
//   defined   - bursts wrap from 2^CNT_W-1 to 1 and continue; ovf_o stays 0
//   undefined - a burst that emits 2^CNT_W-1 with values still pending ends
//               there and reports done_o together with ovf_o
//
// Output timing: the output register is written at the same edge that decides
// the next state, so the first value appears in the cycle right after LOAD and
// done_o coincides with the DONE state. cmd_ready_o is a decode of registers.
// -----------------------------------------------------------------------------
module odd_cnt_sched
    import odd_cnt_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    odd_cnt_sched_if.slave   cmd,
    input  logic             hold_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             cnt_valid_o,
    output logic             done_o,
    output logic             ovf_o,
    output logic             busy_o
);

    localparam logic [CNT_W-1:0] MAX_VAL = '1;

    state_e           state;
    logic             in_reset;   // keeps cmd_ready_o low while reset is held
    logic [CNT_W-1:0] start_q;
    logic [CNT_W-1:0] rem_q;      // values still to emit after the current one
    logic [CNT_W-1:0] core_val;
    logic             core_load;
    logic             core_step;
    logic             at_max;
    logic             accept;

    assign cmd.cmd_ready_o = (state == IDLE) && !in_reset;
    assign accept          = cmd.cmd_valid_i && cmd.cmd_ready_o;

`ifdef ODD_CNT_SCHED_WRAP_EN
    assign at_max = 1'b0;
`else
    // Reaching the top value ends the burst instead of wrapping to 1.
    assign at_max = (core_val == MAX_VAL);
`endif

    // The core steps exactly when RUN emits a fresh value.
    assign core_load = (state == LOAD);
    assign core_step = (state == RUN) && !hold_i && (rem_q != '0) && !at_max;

    odd_cnt_core #(
        .CNT_W    (CNT_W)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (core_load),
        .load_val (start_q),
        .step     (core_step),
        .value    (core_val)
    );

    assign cnt_o = core_val;

    // Captured start value: pure data, only meaningful after a handshake.
    always_ff @(posedge clk) begin
        if (accept) begin
            start_q <= CNT_W'(force_odd(64'(cmd.cmd_start_i)));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            in_reset    <= 1'b1;
            rem_q       <= '0;
            cnt_valid_o <= 1'b0;
            done_o      <= 1'b0;
            ovf_o       <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            in_reset    <= 1'b0;
            cnt_valid_o <= 1'b0;
            done_o      <= 1'b0;
            ovf_o       <= 1'b0;
            case (state)
                IDLE: begin
                    busy_o <= accept;
                    if (accept) begin
                        rem_q <= cmd.cmd_len_i;
                        if (cmd.cmd_len_i == '0) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    // The core takes start_q at this edge, so the first value
                    // is presented in the following cycle.
                    state       <= RUN;
                    cnt_valid_o <= 1'b1;
                    rem_q       <= rem_q - 1'b1;
                    busy_o      <= 1'b1;
                end
                RUN: begin
                    busy_o <= 1'b1;
                    if (!hold_i) begin
                        if ((rem_q == '0) || at_max) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                            ovf_o  <= at_max && (rem_q != '0);
                        end else begin
                            cnt_valid_o <= 1'b1;
                            rem_q       <= rem_q - 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_odd_cnt_sched.sv
// -----------------------------------------------------------------------------
// tb_odd_cnt_sched
// Self-checking bench for odd_cnt_sched. Expected odd values for each burst
// are computed arithmetically from start/length; the bench then walks the
// cycle timeline (LOAD, values with hold gaps, DONE, back to IDLE).
// Define ODD_CNT_SCHED_WRAP_EN for both RTL and bench to test the wrap build.
// -----------------------------------------------------------------------------
module tb_odd_cnt_sched;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         hold_i;
    logic [W-1:0] cnt_o;
    logic         cnt_valid_o;
    logic         done_o;
    logic         ovf_o;
    logic         busy_o;

    odd_cnt_sched_if #(.CNT_W(W)) cmd_if ();

    odd_cnt_sched #(.CNT_W(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd         (cmd_if),
        .hold_i      (hold_i),
        .cnt_o       (cnt_o),
        .cnt_valid_o (cnt_valid_o),
        .done_o      (done_o),
        .ovf_o       (ovf_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] exp_vals[$];
    bit           exp_trunc;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Compare every output; cnt is skipped when chk_cnt is 0 (value unspecified).
    task automatic check_outs(input string tag, input bit v, input bit chk_cnt,
                              input logic [W-1:0] c, input bit d, input bit o,
                              input bit b, input bit r);
        check_eq({tag, ".valid"}, cnt_valid_o, v);
        if (chk_cnt) check_eq({tag, ".cnt"}, cnt_o, c);
        check_eq({tag, ".done"}, done_o, d);
        check_eq({tag, ".ovf"}, ovf_o, o);
        check_eq({tag, ".busy"}, busy_o, b);
        check_eq({tag, ".ready"}, cmd_if.cmd_ready_o, r);
    endtask

    // Reference: value i of a burst is (start|1) + 2*i taken modulo 2^W, or the
    // burst stops (truncated) once the unwrapped value would exceed 2^W-1.
    task automatic build_model(input logic [W-1:0] s, input int len);
        int u;
        exp_vals.delete();
        exp_trunc = 1'b0;
        for (int i = 0; i < len; i++) begin
            u = int'(s | 1) + 2 * i;
            if (u >= (1 << W)) begin
`ifdef ODD_CNT_SCHED_WRAP_EN
                u = u % (1 << W);
`else
                exp_trunc = 1'b1;
                break;
`endif
            end
            exp_vals.push_back(W'(u));
        end
    endtask

    // Returns #1 after the accepting edge.
    task automatic issue(input logic [W-1:0] s, input logic [W-1:0] len);
        int waited = 0;
        @(negedge clk);
        while (!cmd_if.cmd_ready_o && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check_eq("ready_wait", cmd_if.cmd_ready_o, 1);
        cmd_if.cmd_valid_i = 1'b1;
        cmd_if.cmd_start_i = s;
        cmd_if.cmd_len_i   = len;
        @(posedge clk);
        #1 cmd_if.cmd_valid_i = 1'b0;
    endtask

    // hmask bit j = hold_i sampled at the j-th RUN edge.
    task automatic run_cmd(input logic [W-1:0] s, input logic [W-1:0] len, input logic [31:0] hmask);
        int idx = 0;
        int j   = 0;
        bit h;
        bit ended = 1'b0;
        build_model(s, int'(len));
        issue(s, len);
        @(negedge clk);
        if (len != 0) begin
            check_outs("load", 0, 0, '0, 0, 0, 1, 0);
            hold_i = 1'($urandom_range(0, 1));   // must not matter in LOAD
            @(negedge clk);
            check_outs("first", 1, 1, exp_vals[0], 0, 0, 1, 0);
            while (j < 100) begin
                h = (j < 32) ? hmask[j] : 1'b0;
                hold_i = h;
                j++;
                @(negedge clk);
                if (h) begin
                    check_outs("held", 0, 1, exp_vals[idx], 0, 0, 1, 0);
                end else begin
                    idx++;
                    if (idx >= exp_vals.size()) begin
                        ended = 1'b1;
                        break;
                    end
                    check_outs("value", 1, 1, exp_vals[idx], 0, 0, 1, 0);
                end
            end
            check_eq("burst_end_bound", ended, 1);
        end
        check_outs("done", 0, 0, '0, 1, exp_trunc, 1, 0);
        hold_i = 1'b0;
        // A command offered during DONE must be ignored.
        cmd_if.cmd_valid_i = 1'b1;
        cmd_if.cmd_start_i = W'($urandom);
        cmd_if.cmd_len_i   = W'(5);
        @(posedge clk);
        #1 cmd_if.cmd_valid_i = 1'b0;
        @(negedge clk);
        check_outs("idle", 0, 0, '0, 0, 0, 0, 1);
    endtask

    initial begin
        reset              = 1'b1;
        hold_i             = 1'b0;
        cmd_if.cmd_valid_i = 1'b0;
        cmd_if.cmd_start_i = '0;
        cmd_if.cmd_len_i   = '0;

        @(negedge clk);
        @(negedge clk);
        check_outs("reset", 0, 1, '0, 0, 0, 0, 0);
        reset = 1'b0;
        @(negedge clk);
        check_outs("post_reset", 0, 1, '0, 0, 0, 0, 1);

        run_cmd(8'd3,   8'd4, 32'h0);
        run_cmd(8'd4,   8'd2, 32'h0);
        run_cmd(8'd0,   8'd0, 32'h0);
        run_cmd(8'd1,   8'd3, 32'h3);
        run_cmd(8'd253, 8'd4, 32'h0);
        run_cmd(8'd254, 8'd1, 32'h0);
        run_cmd(8'd255, 8'd3, 32'h5);

        // Reset in the middle of a burst, right after value 7 is shown.
        issue(8'd1, 8'd10);
        @(negedge clk);
        check_outs("mid_load", 0, 0, '0, 0, 0, 1, 0);
        for (int v = 1; v <= 7; v += 2) begin
            @(negedge clk);
            check_outs("mid_value", 1, 1, W'(v), 0, 0, 1, 0);
        end
        reset = 1'b1;
        @(negedge clk);
        check_outs("mid_reset", 0, 1, '0, 0, 0, 0, 0);
        reset = 1'b0;
        @(negedge clk);
        check_outs("mid_recover", 0, 1, '0, 0, 0, 0, 1);
        run_cmd(8'd1, 8'd1, 32'h0);

        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] s;
            logic [W-1:0] len;
            s   = ($urandom_range(0, 3) == 0) ? W'($urandom_range(240, 255)) : W'($urandom);
            len = W'($urandom_range(0, 20));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_cmd(s, len, $urandom & $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
